// File: rtl/pulse_sequencer_if.sv
// FIFO-side and DAC-side signal bundle for pulse_sequencer.
// The sequencer takes the slave view; a FIFO/DAC model or test bench takes the master view.
interface pulse_sequencer_if #(
  parameter int DUR_W = 16,
  parameter int AMP_W = 16,
  parameter int CNT_W = 16
) ();
  logic                   start;
  logic                   stop;
  logic [DUR_W+AMP_W-1:0] fifo_dout;
  logic                   fifo_empty;
  logic                   fifo_read;
  logic [AMP_W-1:0]       dac_data;
  logic                   dac_valid;
  logic                   busy;
  logic                   done;
  logic                   underflow;
  logic [CNT_W-1:0]       seg_count;

  modport slave (
    input  start, stop, fifo_dout, fifo_empty,
    output fifo_read, dac_data, dac_valid, busy, done, underflow, seg_count
  );

  modport master (
    output start, stop, fifo_dout, fifo_empty,
    input  fifo_read, dac_data, dac_valid, busy, done, underflow, seg_count
  );
endinterface

// File: rtl/pulse_sequencer.sv
// Plays {duration, amplitude} instruction words from a FIFO as a gapless DAC sample
// stream, with a one-word prefetch register so segments of 3+ cycles chain seamlessly.
module pulse_sequencer #(
  parameter int DUR_W = 16,
  parameter int AMP_W = 16,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  pulse_sequencer_if.slave bus
);
  localparam int WORD_W = DUR_W + AMP_W;

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_PLAY} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [DUR_W-1:0]    r_remaining;
  logic [WORD_W-1:0]   r_nxt_word;
  logic                r_nxt_valid;
  logic                r_rd_pending;
  logic [AMP_W-1:0]    r_dac_data;
  logic                r_dac_valid;
  logic                r_done;
  logic                r_underflow;
  logic [CNT_W-1:0]    r_seg_count;

  logic [DUR_W-1:0]    w_nxt_dur;
  logic [AMP_W-1:0]    w_nxt_amp;
  logic                w_busy;
  logic                w_fifo_read;
  logic                w_start_seq;
  logic                w_load;
  logic                w_consume;
  logic                w_done;
  logic                w_uflow;
  logic                w_flush;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_nxt_dur   = r_nxt_word[WORD_W-1:AMP_W];
  assign w_nxt_amp   = r_nxt_word[AMP_W-1:0];
  assign w_busy      = (r_state != S_IDLE);
  // At most one read in flight, and none once a word (possibly the end marker) is parked.
  assign w_fifo_read = w_busy & ~r_nxt_valid & ~r_rd_pending & ~bus.fifo_empty & ~bus.stop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_start_seq  = 1'b0;
    w_load       = 1'b0;
    w_consume    = 1'b0;
    w_done       = 1'b0;
    w_uflow      = 1'b0;
    w_flush      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          w_start_seq  = 1'b1;
          w_next_state = S_PRIME;
        end
      end
      S_PRIME: begin
        if (bus.stop) begin
          w_flush      = 1'b1;
          w_next_state = S_IDLE;
        end else if (r_nxt_valid) begin
          w_consume = 1'b1;
          if (w_nxt_dur == '0) begin
            w_done       = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_load       = 1'b1;
            w_next_state = S_PLAY;
          end
        end
      end
      S_PLAY: begin
        if (bus.stop) begin
          w_flush      = 1'b1;
          w_next_state = S_IDLE;
        end else if (r_remaining == DUR_W'(1)) begin
          if (r_nxt_valid) begin
            w_consume = 1'b1;
            if (w_nxt_dur == '0) begin
              w_done       = 1'b1;
              w_next_state = S_IDLE;
            end else begin
              w_load = 1'b1;
            end
          end else begin
            // Late prefetch: the in-flight word still lands in r_nxt_word and is kept.
            w_uflow      = 1'b1;
            w_next_state = S_IDLE;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_pending <= 1'b0;
      r_nxt_valid  <= 1'b0;
      r_nxt_word   <= '0;
      r_remaining  <= '0;
      r_dac_data   <= '0;
      r_dac_valid  <= 1'b0;
      r_done       <= 1'b0;
      r_underflow  <= 1'b0;
      r_seg_count  <= '0;
    end else begin
      r_rd_pending <= w_fifo_read & ~w_flush;
      if (w_flush || w_consume)
        r_nxt_valid <= 1'b0;
      else if (r_rd_pending)
        r_nxt_valid <= 1'b1;
      if (r_rd_pending && !w_flush)
        r_nxt_word <= bus.fifo_dout;

      if (w_load)
        r_remaining <= w_nxt_dur;
      else if (r_state == S_PLAY)
        r_remaining <= r_remaining - 1'b1;

      if (w_load) begin
        r_dac_data  <= w_nxt_amp;
        r_dac_valid <= 1'b1;
      end else if (w_next_state == S_IDLE) begin
        r_dac_data  <= '0;
        r_dac_valid <= 1'b0;
      end

      r_done <= w_done;

      if (w_start_seq)
        r_underflow <= 1'b0;
      else if (w_uflow)
        r_underflow <= 1'b1;

      if (w_start_seq)
        r_seg_count <= '0;
      else if (w_load)
        r_seg_count <= sat_inc(r_seg_count);
    end
  end

  assign bus.fifo_read = w_fifo_read;
  assign bus.dac_data  = r_dac_data;
  assign bus.dac_valid = r_dac_valid;
  assign bus.busy      = w_busy;
  assign bus.done      = r_done;
  assign bus.underflow = r_underflow;
  assign bus.seg_count = r_seg_count;
endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer: a table of whole instruction sequences plus
// hand-written stall, stop, retained-word and asynchronous-reset scenarios.
module tb_pulse_sequencer;
  logic clk;
  logic reset;

  pulse_sequencer_if #(.DUR_W(16), .AMP_W(16), .CNT_W(16)) bus ();

  pulse_sequencer #(.DUR_W(16), .AMP_W(16), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: word appears on dout the cycle after the read strobe.
  logic [31:0] mem [0:255];
  int          wr_ptr;
  int          rd_ptr;
  logic [31:0] fifo_q;

  initial begin
    rd_ptr = 0;
    fifo_q = '0;
  end

  always @(posedge clk) begin
    if (bus.fifo_read && (rd_ptr != wr_ptr)) begin
      fifo_q <= mem[rd_ptr % 256];
      rd_ptr <= rd_ptr + 1;
    end
  end

  assign bus.fifo_dout  = fifo_q;
  assign bus.fifo_empty = (wr_ptr == rd_ptr);

  int checks;
  int errors;

  typedef struct {
    logic [31:0] w [4];
    int          nw;
    int          exp_valid;
    int          exp_seg;
    int          exp_done;
    logic        exp_uf;
    int          exp_reads;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_ptr % 256] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [15:0] exp_amp(input vec_t v, input int k);
    int r;
    r = k;
    for (int i = 0; i < v.nw; i++) begin
      if (v.w[i][31:16] == 16'd0) return 16'h0;
      if (r < int'(v.w[i][31:16])) return v.w[i][15:0];
      r = r - int'(v.w[i][31:16]);
    end
    return 16'h0;
  endfunction

  function automatic vec_t mk(input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3,
                              input int nw, input int ev, input int es,
                              input int ed, input logic eu, input int er);
    vec_t v;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.nw = nw; v.exp_valid = ev; v.exp_seg = es;
    v.exp_done = ed; v.exp_uf = eu; v.exp_reads = er;
    return v;
  endfunction

  // Pulses start, then watches until busy drops, tallying the output stream.
  task automatic play(input vec_t v, input string tag,
                      output int nv, output int nd, output int gap, output int bad);
    int first;
    int last;
    int timeout;
    nv = 0; nd = 0; bad = 0; first = -1; last = -1; timeout = 1;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (bus.dac_valid) begin
        if (bus.dac_data !== exp_amp(v, nv)) bad++;
        if (first < 0) first = c;
        last = c;
        nv++;
      end
      if (bus.done) nd++;
      if (!bus.busy) begin
        timeout = 0;
        break;
      end
      @(negedge clk);
    end
    gap = (nv == 0) ? 0 : (last - first + 1 - nv);
    chk({tag, ".timeout"}, 64'(timeout), 64'd0);
  endtask

  initial begin
    int nv, nd, gap, bad, rd0;
    vec_t v;
    checks = 0;
    errors = 0;
    wr_ptr = 0;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;

    tbl[0] = mk({16'd5, 16'h1234}, 32'h0, 32'h0, 32'h0, 2, 5, 1, 1, 1'b0, 2);
    tbl[1] = mk({16'd4, 16'h0100}, {16'd3, 16'h0200}, {16'd6, 16'h0300}, 32'h0,
                4, 13, 3, 1, 1'b0, 4);
    tbl[2] = mk({16'd2, 16'hAAAA}, {16'd5, 16'hBBBB}, 32'h0, 32'h0, 2, 2, 1, 0, 1'b1, 2);
    tbl[3] = mk({16'd3, 16'h0011}, {16'd1, 16'h0022}, 32'h0, 32'h0, 3, 4, 2, 0, 1'b1, 3);
    tbl[4] = mk(32'h0, 32'h0, 32'h0, 32'h0, 1, 0, 0, 1, 1'b0, 1);
    tbl[5] = mk({16'd1, 16'h5555}, 32'h0, 32'h0, 32'h0, 2, 1, 1, 0, 1'b1, 2);

    // Reset state, with a word already waiting in the FIFO.
    push({16'd7, 16'h7777});
    repeat (3) @(negedge clk);
    chk("rst.dac_valid", 64'(bus.dac_valid), 64'd0);
    chk("rst.dac_data",  64'(bus.dac_data),  64'd0);
    chk("rst.busy",      64'(bus.busy),      64'd0);
    chk("rst.done",      64'(bus.done),      64'd0);
    chk("rst.underflow", 64'(bus.underflow), 64'd0);
    chk("rst.seg_count", 64'(bus.seg_count), 64'd0);
    chk("rst.fifo_read", 64'(bus.fifo_read), 64'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle.no_read", 64'(rd_ptr), 64'd0);
    wr_ptr = rd_ptr;

    for (int i = 0; i < 6; i++) begin
      do_reset();
      rd0 = rd_ptr;
      for (int j = 0; j < tbl[i].nw; j++) push(tbl[i].w[j]);
      play(tbl[i], $sformatf("vec%0d", i), nv, nd, gap, bad);
      chk($sformatf("vec%0d.valid_cycles", i), 64'(nv), 64'(tbl[i].exp_valid));
      chk($sformatf("vec%0d.gap", i),          64'(gap), 64'd0);
      chk($sformatf("vec%0d.data_errs", i),    64'(bad), 64'd0);
      chk($sformatf("vec%0d.done_count", i),   64'(nd),  64'(tbl[i].exp_done));
      chk($sformatf("vec%0d.seg_count", i),    64'(bus.seg_count), 64'(tbl[i].exp_seg));
      chk($sformatf("vec%0d.underflow", i),    64'(bus.underflow), 64'(tbl[i].exp_uf));
      chk($sformatf("vec%0d.reads", i),        64'(rd_ptr - rd0), 64'(tbl[i].exp_reads));
      @(negedge clk);
      chk($sformatf("vec%0d.done_single", i),  64'(bus.done), 64'd0);
      chk($sformatf("vec%0d.dac_zero", i),     64'(bus.dac_data), 64'd0);
    end

    // Underflow keeps the late word; the next start clears the flag and plays it.
    do_reset();
    push({16'd2, 16'hAAAA});
    push({16'd5, 16'hBBBB});
    v = mk({16'd2, 16'hAAAA}, 32'h0, 32'h0, 32'h0, 2, 0, 0, 0, 1'b0, 0);
    play(v, "uf1", nv, nd, gap, bad);
    chk("uf1.underflow", 64'(bus.underflow), 64'd1);
    chk("uf1.done", 64'(nd), 64'd0);
    repeat (2) @(negedge clk);
    chk("uf1.sticky", 64'(bus.underflow), 64'd1);
    push(32'h0);
    v = mk({16'd5, 16'hBBBB}, 32'h0, 32'h0, 32'h0, 2, 0, 0, 0, 1'b0, 0);
    play(v, "uf2", nv, nd, gap, bad);
    chk("uf2.underflow_cleared", 64'(bus.underflow), 64'd0);
    chk("uf2.valid_cycles", 64'(nv), 64'd5);
    chk("uf2.data_errs", 64'(bad), 64'd0);
    chk("uf2.done", 64'(nd), 64'd1);
    chk("uf2.seg_count", 64'(bus.seg_count), 64'd1);

    // Prime stall on an empty FIFO, then an end marker arrives.
    do_reset();
    rd0 = rd_ptr;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    nv = 0;
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.busy !== 1'b1) nd++;
      if (bus.dac_valid !== 1'b0) nv++;
      @(negedge clk);
    end
    chk("stall.busy_drops", 64'(nd), 64'd0);
    chk("stall.valid_cycles", 64'(nv), 64'd0);
    chk("stall.reads", 64'(rd_ptr - rd0), 64'd0);
    push(32'h0);
    nd = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (bus.done) nd = c;
    end
    chk("stall.done_cycle", 64'(nd), 64'd3);
    chk("stall.busy_after", 64'(bus.busy), 64'd0);
    chk("stall.seg_count", 64'(bus.seg_count), 64'd0);

    // start and stop together while idle: stop wins.
    do_reset();
    rd0 = rd_ptr;
    push({16'd100, 16'h7FFF});
    push({16'd4, 16'h1111});
    push({16'd3, 16'h2222});
    push(32'h0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("startstop.busy", 64'(bus.busy), 64'd0);
    chk("startstop.reads", 64'(rd_ptr - rd0), 64'd0);

    // Stop mid-playback, with an ignored start while busy.
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    nd = 1;
    for (int c = 0; c < 20; c++) begin
      if (bus.dac_valid) begin
        nd = 0;
        break;
      end
      @(negedge clk);
    end
    chk("stop.first_valid_timeout", 64'(nd), 64'd0);
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      bus.start = (k == 4);
    end
    bus.start = 1'b0;
    chk("stop.still_playing", 64'(bus.dac_valid), 64'd1);
    chk("stop.data", 64'(bus.dac_data), 64'h7FFF);
    chk("stop.seg_before", 64'(bus.seg_count), 64'd1);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    chk("stop.dac_valid", 64'(bus.dac_valid), 64'd0);
    chk("stop.busy", 64'(bus.busy), 64'd0);
    chk("stop.done", 64'(bus.done), 64'd0);
    chk("stop.underflow", 64'(bus.underflow), 64'd0);
    chk("stop.seg_count", 64'(bus.seg_count), 64'd1);
    chk("stop.reads", 64'(rd_ptr - rd0), 64'd2);
    v = mk({16'd3, 16'h2222}, 32'h0, 32'h0, 32'h0, 2, 0, 0, 0, 1'b0, 0);
    play(v, "restart", nv, nd, gap, bad);
    chk("restart.valid_cycles", 64'(nv), 64'd3);
    chk("restart.data_errs", 64'(bad), 64'd0);
    chk("restart.done", 64'(nd), 64'd1);
    chk("restart.seg_count", 64'(bus.seg_count), 64'd1);

    // Asynchronous reset between clock edges during playback.
    do_reset();
    push({16'd50, 16'h4242});
    push(32'h0);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    chk("arst.pre_valid", 64'(bus.dac_valid), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst.dac_valid", 64'(bus.dac_valid), 64'd0);
    chk("arst.dac_data", 64'(bus.dac_data), 64'd0);
    chk("arst.busy", 64'(bus.busy), 64'd0);
    chk("arst.seg_count", 64'(bus.seg_count), 64'd0);
    chk("arst.fifo_read", 64'(bus.fifo_read), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("arst.stays_idle", 64'(bus.busy), 64'd0);
    chk("arst.no_valid", 64'(bus.dac_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
